// File: rtl/rv_multicycle_ctrl_if.sv
// Control/decoder/memory-handshake bundle between the RV32I multicycle controller and its datapath.
interface rv_multicycle_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [4:0]       rd;
   logic             mem_ready;
   logic             br_taken;
   logic             mem_req;
   logic             mem_we;
   logic             iord;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             reg_write;
   logic [1:0]       wb_sel;
   logic             alu_src_b;
   logic [1:0]       alu_op;
   logic             illegal;
   logic             timeout;
   logic [CNT_W-1:0] instret;

   modport master (
      input  opcode, funct3, rd, mem_ready, br_taken,
      output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
             wb_sel, alu_src_b, alu_op, illegal, timeout, instret
   );

   modport slave (
      output opcode, funct3, rd, mem_ready, br_taken,
      input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
             wb_sel, alu_src_b, alu_op, illegal, timeout, instret
   );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multicycle control FSM: fetch/decode/exec/mem/wb sequencing, retire counter,
// memory-wait watchdog and illegal-opcode trap.
module rv_multicycle_ctrl #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic                  clk,
   input logic                  rst,
   rv_multicycle_ctrl_if.master bus
);
   localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
   typedef enum logic [3:0] {
      C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
   } class_t;

   function automatic class_t decode_class(input logic [6:0] op);
      case (op)
         7'h33:   return C_R;
         7'h13:   return C_I;
         7'h03:   return C_LOAD;
         7'h23:   return C_STORE;
         7'h63:   return C_BRANCH;
         7'h6F:   return C_JAL;
         7'h67:   return C_JALR;
         7'h37:   return C_LUI;
         7'h17:   return C_AUIPC;
         default: return C_ILL;
      endcase
   endfunction

   state_t           state;
   class_t           cls;
   logic [WD_W-1:0]  wd;
   logic [CNT_W-1:0] instret_q;
   logic             illegal_q;
   logic             timeout_q;
   logic             rw;
   logic             retire_c;
   logic             waiting_c;
   logic             expired_c;
   class_t           dec_cls_c;
   logic             unused_funct3;

   assign unused_funct3 = ^bus.funct3;
   assign dec_cls_c     = decode_class(bus.opcode);
   assign waiting_c     = ((state == S_FETCH) || (state == S_MEM)) && !bus.mem_ready;
   assign expired_c     = waiting_c && (wd == WD_LAST);

   // Outputs: Moore decode of state/class, qualified by mem_ready in the memory phases.
   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.iord      = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_src    = 2'd0;
      bus.wb_sel    = 2'd0;
      bus.alu_src_b = 1'b0;
      bus.alu_op    = 2'd0;
      rw            = 1'b0;
      retire_c      = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               bus.mem_req  = 1'b1;
               bus.ir_write = bus.mem_ready;
               bus.pc_write = bus.mem_ready;
            end
            S_EXEC: begin
               case (cls)
                  C_R, C_I: begin
                     bus.alu_op    = 2'd2;
                     bus.alu_src_b = (cls == C_I);
                  end
                  C_LOAD, C_STORE, C_LUI, C_AUIPC: bus.alu_src_b = 1'b1;
                  C_BRANCH: begin
                     bus.alu_op   = 2'd1;
                     bus.pc_write = bus.br_taken;
                     bus.pc_src   = 2'd1;
                     retire_c     = 1'b1;
                  end
                  C_JAL, C_JALR: begin
                     bus.pc_write = 1'b1;
                     bus.pc_src   = (cls == C_JAL) ? 2'd1 : 2'd2;
                     bus.wb_sel   = 2'd2;
                     rw           = 1'b1;
                     retire_c     = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               bus.mem_req = 1'b1;
               bus.iord    = 1'b1;
               bus.mem_we  = (cls == C_STORE);
               retire_c    = bus.mem_ready && (cls == C_STORE);
            end
            S_WB: begin
               rw         = 1'b1;
               bus.wb_sel = (cls == C_LOAD) ? 2'd1 : 2'd0;
               retire_c   = 1'b1;
            end
            default: ;
         endcase
      end
      bus.reg_write = rw && (bus.rd != 5'd0);
   end

   assign bus.illegal = illegal_q;
   assign bus.timeout = timeout_q;
   assign bus.instret = instret_q;

   // State, opcode class, watchdog, retire counter and sticky trap flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FETCH;
         cls       <= C_ILL;
         wd        <= '0;
         instret_q <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (retire_c) instret_q <= instret_q + CNT_W'(1);
         wd <= waiting_c ? (wd + WD_W'(1)) : '0;
         if (expired_c) begin
            timeout_q <= 1'b1;
            state     <= S_TRAP;
         end else begin
            case (state)
               S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
               S_DECODE: begin
                  cls <= dec_cls_c;
                  if (dec_cls_c == C_ILL) begin
                     illegal_q <= 1'b1;
                     state     <= S_TRAP;
                  end else begin
                     state <= S_EXEC;
                  end
               end
               S_EXEC: begin
                  case (cls)
                     C_R, C_I, C_LUI, C_AUIPC: state <= S_WB;
                     C_LOAD, C_STORE:          state <= S_MEM;
                     default:                  state <= S_FETCH;
                  endcase
               end
               S_MEM:    if (bus.mem_ready) state <= (cls == C_LOAD) ? S_WB : S_FETCH;
               S_WB:     state <= S_FETCH;
               default:  state <= S_TRAP;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench: each instruction is expanded into its expected cycle-by-cycle control pattern.
module tb_rv_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rv_multicycle_ctrl_if #(.CNT_W(32)) bus ();
   rv_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic        rdy;
      logic        br;
      logic [12:0] exp;
      logic [31:0] inst;
      logic        ill;
      logic        tmo;
   } cyc_t;

   cyc_t        sched[$];
   logic [31:0] m_instret = '0;
   logic        m_ill = 1'b0;
   logic        m_tmo = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          sz;

   wire logic [12:0] act = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                            bus.pc_src, bus.reg_write, bus.wb_sel, bus.alu_src_b, bus.alu_op};

   function automatic logic [12:0] pk(input logic req, input logic we, input logic iord,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] wbs, input logic asb,
                                      input logic [1:0] aop);
      return {req, we, iord, irw, pcw, pcs, rw, wbs, asb, aop};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic push(input logic [6:0] op, input logic [4:0] rd, input logic rdy,
                       input logic br, input logic [12:0] exp);
      cyc_t c;
      c.op = op; c.rd = rd; c.rdy = rdy; c.br = br; c.exp = exp;
      c.inst = m_instret; c.ill = m_ill; c.tmo = m_tmo;
      sched.push_back(c);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic add_fetch(input int fw);
      for (int i = 0; i < fw; i++)
         push(7'($urandom), 5'($urandom), 1'b0, rb(), pk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0));
      push(7'($urandom), 5'($urandom), 1'b1, rb(), pk(1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 0, 2'd0));
   endtask

   task automatic add_trap_cycles(input int n);
      for (int i = 0; i < n; i++) push(7'($urandom), 5'($urandom), rb(), rb(), 13'd0);
   endtask

   // Expected behaviour of one legal instruction given its fetch and memory wait counts.
   task automatic add_instr(input logic [6:0] op, input logic [4:0] rd, input logic br,
                            input int fw, input int mw);
      logic rwv, ld, st, to_mem, to_wb;
      rwv = (rd != 5'd0);
      ld  = (op == 7'h03);
      st  = (op == 7'h23);
      to_mem = ld || st;
      to_wb  = (op == 7'h33) || (op == 7'h13) || (op == 7'h37) || (op == 7'h17);
      add_fetch(fw);
      push(op, rd, rb(), rb(), 13'd0);
      case (op)
         7'h33: push(op, rd, rb(), rb(), pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd2));
         7'h13: push(op, rd, rb(), rb(), pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 2'd2));
         7'h63: begin
            push(op, rd, rb(), br, pk(0, 0, 0, 0, br, 2'd1, 0, 2'd0, 0, 2'd1));
            m_instret++;
         end
         7'h6F: begin
            push(op, rd, rb(), rb(), pk(0, 0, 0, 0, 1, 2'd1, rwv, 2'd2, 0, 2'd0));
            m_instret++;
         end
         7'h67: begin
            push(op, rd, rb(), rb(), pk(0, 0, 0, 0, 1, 2'd2, rwv, 2'd2, 0, 2'd0));
            m_instret++;
         end
         default: push(op, rd, rb(), rb(), pk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 2'd0));
      endcase
      if (to_mem) begin
         for (int i = 0; i <= mw; i++)
            push(op, rd, (i == mw), rb(), pk(1, st, 1, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0));
         if (st) m_instret++;
      end
      if (to_wb || ld) begin
         push(op, rd, rb(), rb(), pk(0, 0, 0, 0, 0, 2'd0, rwv, ld ? 2'd1 : 2'd0, 0, 2'd0));
         m_instret++;
      end
   endtask

   task automatic run_sched(input int n);
      for (int i = 0; i < n && i < sched.size(); i++) begin
         bus.opcode    = sched[i].op;
         bus.rd        = sched[i].rd;
         bus.mem_ready = sched[i].rdy;
         bus.br_taken  = sched[i].br;
         bus.funct3    = 3'($urandom);
         @(negedge clk);
         chk($sformatf("strobes[%0d]", i), 64'(act), 64'(sched[i].exp));
         chk($sformatf("instret[%0d]", i), 64'(bus.instret), 64'(sched[i].inst));
         chk($sformatf("flags[%0d]", i), 64'({bus.illegal, bus.timeout}),
             64'({sched[i].ill, sched[i].tmo}));
         @(posedge clk);
         #1;
      end
      sched.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode    = 7'h13;
      bus.rd        = 5'd1;
      bus.br_taken  = 1'b1;
      @(negedge clk);
      chk("reset_strobes", 64'(act), 64'd0);
      chk("reset_instret", 64'(bus.instret), 64'd0);
      chk("reset_flags", 64'({bus.illegal, bus.timeout}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_instret = '0;
      m_ill = 1'b0;
      m_tmo = 1'b0;
   endtask

   initial begin
      bus.funct3 = 3'd0;
      do_reset();

      add_instr(7'h13, 5'd1, 1'b0, 0, 0);
      sz = sched.size(); chk("addi_len", 64'(sz), 64'd4);
      run_sched(sz);
      chk("addi_instret", 64'(bus.instret), 64'd1);

      add_instr(7'h03, 5'd5, 1'b0, 0, 3);
      sz = sched.size(); chk("lw_len", 64'(sz), 64'd8);
      run_sched(sz);

      add_instr(7'h63, 5'd3, 1'b0, 0, 0);
      sz = sched.size(); chk("beq_nt_len", 64'(sz), 64'd3);
      run_sched(sz);
      add_instr(7'h63, 5'd3, 1'b1, 0, 0);
      run_sched(sched.size());

      add_instr(7'h33, 5'd0, 1'b0, 0, 0);
      add_instr(7'h23, 5'd7, 1'b0, 0, 0);
      sz = sched.size(); chk("add_sw_len", 64'(sz), 64'd8);
      add_instr(7'h37, 5'd8, 1'b0, 0, 0);
      add_instr(7'h17, 5'd9, 1'b0, 0, 0);
      add_instr(7'h6F, 5'd1, 1'b0, 0, 0);
      add_instr(7'h67, 5'd2, 1'b0, 0, 0);
      add_instr(7'h33, 5'd4, 1'b0, 3, 0);
      add_instr(7'h6F, 5'd0, 1'b0, 0, 0);
      run_sched(sched.size());
      chk("seq_instret", 64'(bus.instret), 64'd12);

      // Abort a load while it waits in the memory phase.
      add_instr(7'h03, 5'd6, 1'b0, 0, 3);
      run_sched(5);
      do_reset();

      add_instr(7'h13, 5'd1, 1'b0, 0, 0);
      add_fetch(0);
      push(7'h7F, 5'd1, rb(), rb(), 13'd0);
      m_ill = 1'b1;
      add_trap_cycles(20);
      run_sched(sched.size());
      chk("illegal_flag", 64'(bus.illegal), 64'd1);
      chk("illegal_instret", 64'(bus.instret), 64'd1);
      do_reset();

      add_instr(7'h13, 5'd2, 1'b0, 0, 0);
      run_sched(sched.size());
      chk("restart_instret", 64'(bus.instret), 64'd1);
      do_reset();

      for (int i = 0; i < 4; i++)
         push(7'($urandom), 5'($urandom), 1'b0, rb(), pk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0));
      m_tmo = 1'b1;
      add_trap_cycles(20);
      run_sched(sched.size());
      chk("timeout_flag", 64'(bus.timeout), 64'd1);
      do_reset();

      add_instr(7'h13, 5'd3, 1'b0, 3, 0);
      run_sched(sched.size());
      chk("late_ready_flags", 64'({bus.illegal, bus.timeout}), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
